// File: rtl/cdc_sync_filt.sv
`default_nettype none
// ============================================================================
// Module   : cdc_sync_filt
// Brief    : Multi-channel level synchronizer with per-bit stability filter
//            and registered rise/fall edge pulses.
// Revision : 1.0 - initial release
// ============================================================================
module cdc_sync_filt #(
    parameter int               WIDTH      = 4,
    parameter int               SYNC_STAGE = 2,
    parameter int               FILT_LEN   = 4,
    parameter logic [WIDTH-1:0] RST_VAL    = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             res,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             chg,
    output logic [WIDTH-1:0] pend
);

    localparam int                 c_cnt_w    = (FILT_LEN > 2) ? $clog2(FILT_LEN) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(FILT_LEN - 1);

    if (WIDTH < 1 || WIDTH > 64) begin : g_chk_width
        $error("cdc_sync_filt: WIDTH out of range (1..64)");
    end
    if (SYNC_STAGE < 0 || SYNC_STAGE > 7) begin : g_chk_sync
        $error("cdc_sync_filt: SYNC_STAGE out of range (0..7)");
    end
    if (FILT_LEN < 1 || FILT_LEN > 255) begin : g_chk_filt
        $error("cdc_sync_filt: FILT_LEN out of range (1..255)");
    end

    logic [WIDTH-1:0]   w_s;
    logic [WIDTH-1:0]   r_dout;
    logic [WIDTH-1:0]   r_rise;
    logic [WIDTH-1:0]   r_fall;
    logic [WIDTH-1:0]   r_pend;
    logic [c_cnt_w-1:0] r_cnt [WIDTH];

    if (SYNC_STAGE == 0) begin : g_sync_bypass
        assign w_s = din;
    end else begin : g_sync_chain
        logic [WIDTH-1:0] r_sync [SYNC_STAGE];

        always_ff @(posedge clk) begin
            if (res) begin
                for (int k = 0; k < SYNC_STAGE; k++) begin
                    r_sync[k] <= RST_VAL;
                end
            end else begin
                r_sync[0] <= din;
                for (int k = 1; k < SYNC_STAGE; k++) begin
                    r_sync[k] <= r_sync[k-1];
                end
            end
        end

        assign w_s = r_sync[SYNC_STAGE-1];
    end

    // A candidate is accepted on the FILT_LEN-th consecutive differing sample;
    // any agreeing sample discards the partial count.
    always_ff @(posedge clk) begin
        if (res) begin
            r_dout <= RST_VAL;
            r_rise <= '0;
            r_fall <= '0;
            r_pend <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (w_s[i] == r_dout[i]) begin
                    r_cnt[i]  <= '0;
                    r_pend[i] <= 1'b0;
                    r_rise[i] <= 1'b0;
                    r_fall[i] <= 1'b0;
                end else if (r_cnt[i] == c_cnt_last) begin
                    r_dout[i] <= w_s[i];
                    r_cnt[i]  <= '0;
                    r_pend[i] <= 1'b0;
                    r_rise[i] <= w_s[i];
                    r_fall[i] <= ~w_s[i];
                end else begin
                    r_cnt[i]  <= r_cnt[i] + 1'b1;
                    r_pend[i] <= 1'b1;
                    r_rise[i] <= 1'b0;
                    r_fall[i] <= 1'b0;
                end
            end
        end
    end

    assign dout = r_dout;
    assign rise = r_rise;
    assign fall = r_fall;
    assign pend = r_pend;
    assign chg  = |(r_rise | r_fall);

endmodule
`default_nettype wire

// File: doc/cdc_sync_filt.md
Name: cdc_sync_filt

Overview:
Multi-channel synchronizer for asynchronous level inputs such as pins, straps and status lines from other clock domains. It has a configurable stage count and per-channel reset value. It adds a per-bit stability (debounce) filter and registered rise/fall edge pulses, so consumers no longer need their own edge detectors. It sits at every asynchronous boundary in place of the plain synchronizer wherever glitch rejection or edge events are needed.

Parameters:
WIDTH, 4, number of independent 1-bit channels (1..64).
SYNC_STAGE, 2, synchronizer flops per channel (0..7); 0 means no sync flops, only for inputs already in the clk domain.
FILT_LEN, 4, consecutive cycles a new synchronized value must hold before it is accepted (1..255); 1 means no filtering, one register only.
RST_VAL, {WIDTH{1'b0}}, reset value of all sync stages and of dout (WIDTH bits).

Ports:
clk  input  1  clock; the whole block is in this domain.
res  input  1  reset, synchronous, active-high.
din  input  WIDTH  asynchronous channel inputs.
dout  output  WIDTH  synchronized, filtered levels (registered).
rise  output  WIDTH  one-cycle pulse per bit when dout bit goes 0->1 (registered).
fall  output  WIDTH  one-cycle pulse per bit when dout bit goes 1->0 (registered).
chg  output  1  OR of all rise and fall bits (combinational from the rise/fall registers).
pend  output  WIDTH  per bit, 1 while the filter counter is non-zero, i.e. a candidate change is being qualified.

Behaviour:
- Reset (res=1 at a clk edge): sync stages <= RST_VAL; dout <= RST_VAL; counters <= 0; rise, fall and pend <= 0. res has priority over all other updates. No edge pulses are generated by reset assertion or release.
- Sync chain: the stage registers shift din through SYNC_STAGE flops. The last stage output is s. If SYNC_STAGE=0, s=din.
- Filter, per bit i, using counter cnt_i of width ceil(log2(FILT_LEN)), minimum 1 bit:
  - s[i]==dout[i]: cnt_i <= 0; no change.
  - s[i]!=dout[i] and cnt_i < FILT_LEN-1: cnt_i <= cnt_i+1.
  - s[i]!=dout[i] and cnt_i == FILT_LEN-1: dout[i] <= s[i]; cnt_i <= 0; rise[i] or fall[i] <= 1 per direction.
  - cnt_i never exceeds FILT_LEN-1, so there is no wrap. With FILT_LEN=1 the counter is held at 0 and every differing sample is accepted immediately.
- Glitch rejection: if s[i] returns to dout[i] before FILT_LEN consecutive differing samples, cnt_i clears and the full count restarts on the next difference.
- Edge outputs: rise/fall are high for exactly one cycle, the first cycle dout shows the new value. Otherwise they are 0. rise[i] and fall[i] are never both 1.
- pend[i] = (cnt_i != 0), registered alongside the counter.
- Latency: din stable from before edge k is accepted on dout at edge k+SYNC_STAGE+FILT_LEN-1. That is SYNC_STAGE+FILT_LEN cycles from the first capturing edge, counting the edge at which din is first sampled as cycle 1.
- Channels are fully independent; simultaneous changes on multiple bits produce simultaneous pulses.
- Reset release with din != RST_VAL: this is treated as a normal change and pulses after the full latency. This is intentional, so consumers see a defined initial event.
- Reset mid-qualification: the count is discarded; after release the full latency applies again.
- Out-of-range parameters are unsupported; the implementation flags them with an elaboration-time error.

Test Plan:
All scenarios use defaults (WIDTH=4, SYNC_STAGE=2, FILT_LEN=4, RST_VAL=0) unless stated.
1. Reset: res=1 for 2 cycles with din=4'hF -> dout=0, rise=fall=0, pend=0 during reset. Release with din held 4'hF -> dout=4'hF on the 6th edge after release, rise=4'hF for exactly 1 cycle, chg=1 for that cycle only.
2. Glitch: din[0]=1 for 3 cycles, then 0 -> dout[0] stays 0, rise=0 throughout, pend[0] pulses high then clears.
3. Threshold: din[1]=1 held for exactly 4 cycles, then 0 held -> dout[1] rises 6 edges after the first sample and rise[1] pulses. After the low is held 4 sampled cycles, dout[1] falls and fall[1] pulses.
4. Concurrent channels: din 0->4'h5 (stable) -> rise=4'h5. Then din 4'h5->4'hA -> in one cycle, rise=4'hA and fall=4'h5, and dout=4'hA.
5. Reset mid-count: din[2]=1; res=1 for 1 cycle after pend[2] has been high for 2 cycles -> cnt cleared, dout[2]=0. After release dout[2] rises at the full 6-edge latency, not earlier.
6. Variant SYNC_STAGE=0, FILT_LEN=1, RST_VAL=4'h3: reset -> dout=4'h3. Drive din=4'h1 -> dout=4'h1 at the next edge with fall=4'h2 for 1 cycle; pend stays 0.
